pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline.
//  Watches ID operands, the EX instruction and the MEM-stage data-memory access.
//  Drives hold/bubble/flush enables to PC, IF/ID, ID/EX and EX/MEM registers.
//  Sequences multi-cycle data-memory accesses with a req/ack handshake and a timeout.
// PARAMETERS
//  LD_FLAG      3'b001  mem_flag encoding for loads
//  ST_FLAG      3'b010  mem_flag encoding for stores
//  MEM_TIMEOUT  15      max freeze cycles before error (1..2^CNT_W-1)
//  CNT_W        4       width of wait counter
// PORTS
//  clk              in   1   clock, all state on posedge
//  reset_n          in   1   one clock; reset is asynchronous and active-low
//  id_rs1, id_rs2   in   5   source register addresses of the instruction in ID
//  id_use_rs1/rs2   in   1   ID instruction actually reads rs1 / rs2
//  ex_rd_addr       in   5   destination of the instruction in EX
//  ex_rd_we         in   1   EX instruction writes rd
//  ex_mem_flag      in   3   memory op class of the EX instruction
//  ex_branch_taken  in   1   branch/jump in EX resolved taken
//  mem_mem_flag     in   3   memory op class held in EX/MEM register
//  mem_ack          in   1   data memory completes access this cycle
//  mem_req          out  1   data-memory request
//  stall_if         out  1   hold PC
//  stall_id         out  1   hold IF/ID
//  stall_ex         out  1   hold ID/EX
//  hold_ex_mem      out  1   hold EX/MEM
//  bubble_ex        out  1   load NOP into ID/EX next edge
//  flush_id         out  1   load NOP into IF/ID next edge
//  mem_err          out  1   sticky memory-timeout error
//  state            out  2   FSM state: 00 RUN, 01 LDUSE, 10 MWAIT, 11 ERR
//  stall_cycles     out  16  saturating count of cycles with stall_if=1
// BEHAVIOUR
//  Reset (reset_n=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0;
//   all stall/bubble/flush/mem_req outputs 0 while reset_n=0.
//  Outputs are combinational from state + inputs; state/counters update on posedge.
//  mem_access = (mem_mem_flag==LD_FLAG)|(mem_mem_flag==ST_FLAG); mem_req = mem_access & state!=ERR.
//  freeze = mem_req & ~mem_ack: stall_if=stall_id=stall_ex=hold_ex_mem=1,
//   bubble_ex=flush_id=0. Access acked in its first cycle costs zero stall.
//  ldhaz = state==RUN & ex_mem_flag==LD_FLAG & ex_rd_we & ex_rd_addr!=0 &
//   ((id_use_rs1 & id_rs1==ex_rd_addr) | (id_use_rs2 & id_rs2==ex_rd_addr)).
//  Priority (highest first): ERR > freeze > branch > ldhaz.
//  branch (ex_branch_taken & ~freeze): flush_id=1, bubble_ex=1, no stalls; ldhaz ignored.
//  ldhaz (no freeze/branch): stall_if=stall_id=1, bubble_ex=1, stall_ex=0; exactly 1 cycle.
//  FSM:
//   RUN  : freeze -> MWAIT (wait_cnt<=1); else ldhaz -> LDUSE; else RUN.
//   LDUSE: ldhaz suppressed; freeze -> MWAIT (wait_cnt<=1); else RUN.
//   MWAIT: mem_ack -> RUN, wait_cnt<=0 (stalls drop in ack cycle);
//          else wait_cnt==MEM_TIMEOUT -> ERR; else wait_cnt<=wait_cnt+1.
//   ERR  : mem_err=1, mem_req=0, stall_if/id/ex/hold_ex_mem=1, bubble/flush=0;
//          exit only via reset_n.
//  Timeout: MEM_TIMEOUT consecutive unacked cycles allowed; ERR entered at edge
//   ending the cycle where wait_cnt==MEM_TIMEOUT and mem_ack=0.
//  mem_ack with mem_access=0 is ignored. Branch during freeze is deferred
//   (EX held; re-evaluated when freeze clears).
//  stall_cycles += 1 each cycle stall_if=1; saturates at 16'hFFFF (no wrap).
//  Reset asserted mid-MWAIT/ERR: immediate return to RUN, counters cleared.
// TESTING
//  LW x5 in EX, ID reads x5 (rs2) -> stall_if/stall_id/bubble_ex=1 one cycle, state RUN->LDUSE->RUN.
//  Same but ex_rd_addr=0 or id_use_rs2=0 -> no stall, stall_cycles unchanged.
//  ex_branch_taken=1 with concurrent ldhaz -> flush_id=1, bubble_ex=1, stall_if=0.
//  SW in MEM, mem_ack after 3 cycles -> freeze 3 cycles, RUN on ack cycle, stall_cycles=3.
//  LW in MEM, mem_ack never -> ERR after 15 waiting cycles, mem_err=1 until reset_n=0.
//  reset_n pulsed low in MWAIT -> outputs 0 immediately, state=RUN, wait_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Pipeline-observation and stall/flush control bundle for the
//          hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic [2:0]  ex_mem_flag;
    logic        ex_branch_taken;
    logic [2:0]  mem_mem_flag;
    logic        mem_ack;

    logic        mem_req;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        hold_ex_mem;
    logic        bubble_ex;
    logic        flush_id;
    logic        mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    // Pipeline side: reports stage contents, receives control enables
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd_addr, ex_rd_we, ex_mem_flag, ex_branch_taken,
        output mem_mem_flag, mem_ack,
        input  mem_req, stall_if, stall_id, stall_ex, hold_ex_mem,
        input  bubble_ex, flush_id, mem_err, state, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd_addr, ex_rd_we, ex_mem_flag, ex_branch_taken,
        input  mem_mem_flag, mem_ack,
        output mem_req, stall_if, stall_id, stall_ex, hold_ex_mem,
        output bubble_ex, flush_id, mem_err, state, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/flush controller for a 5-stage pipeline: load-use hazards,
//          taken branches and multi-cycle data-memory accesses with timeout.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter logic [2:0] LD_FLAG     = 3'b001,
    parameter logic [2:0] ST_FLAG     = 3'b010,
    parameter int         MEM_TIMEOUT = 15,
    parameter int         CNT_W       = 4
) (
    input  wire               clk,
    input  wire               reset_n,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_LDUSE = 2'b01,
        S_MWAIT = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [15:0]      r_stall_cnt;

    logic w_mem_access;
    logic w_mem_req;
    logic w_ack;
    logic w_freeze;
    logic w_raw_haz;
    logic w_ldhaz;
    logic w_stall_if;
    logic w_stall_id;
    logic w_stall_ex;
    logic w_hold_ex_mem;
    logic w_bubble_ex;
    logic w_flush_id;

    assign w_mem_access = (bus.mem_mem_flag == LD_FLAG) || (bus.mem_mem_flag == ST_FLAG);
    // Gating with reset_n keeps every enable low while reset is held
    assign w_mem_req    = reset_n && w_mem_access && (r_state != S_ERR);
    assign w_ack        = bus.mem_ack && w_mem_access;
    assign w_freeze     = w_mem_req && !bus.mem_ack;

    assign w_raw_haz = (bus.ex_mem_flag == LD_FLAG) && bus.ex_rd_we && (bus.ex_rd_addr != 5'd0) &&
                       ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd_addr)) ||
                        (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd_addr)));
    assign w_ldhaz   = (r_state == S_RUN) && w_raw_haz;

    // Output decode, priority ERR > freeze > branch > load-use
    always_comb begin
        w_stall_if    = 1'b0;
        w_stall_id    = 1'b0;
        w_stall_ex    = 1'b0;
        w_hold_ex_mem = 1'b0;
        w_bubble_ex   = 1'b0;
        w_flush_id    = 1'b0;
        if (reset_n) begin
            if ((r_state == S_ERR) || w_freeze) begin
                w_stall_if    = 1'b1;
                w_stall_id    = 1'b1;
                w_stall_ex    = 1'b1;
                w_hold_ex_mem = 1'b1;
            end else if (bus.ex_branch_taken) begin
                w_flush_id  = 1'b1;
                w_bubble_ex = 1'b1;
            end else if (w_ldhaz) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_bubble_ex = 1'b1;
            end
        end
    end

    // A load-use hazard hidden behind a taken branch is dropped: the flush
    // already removes the dependent instruction, so LDUSE is not entered.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = S_MWAIT;
                    w_wait_nxt  = C_ONE;
                end else if (w_ldhaz && !bus.ex_branch_taken) begin
                    w_state_nxt = S_LDUSE;
                end
            end
            S_LDUSE: begin
                if (w_freeze) begin
                    w_state_nxt = S_MWAIT;
                    w_wait_nxt  = C_ONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_MWAIT: begin
                if (w_ack) begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == C_TIMEOUT) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wait_nxt = r_wait_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_stall_if && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.stall_if     = w_stall_if;
    assign bus.stall_id     = w_stall_id;
    assign bus.stall_ex     = w_stall_ex;
    assign bus.hold_ex_mem  = w_hold_ex_mem;
    assign bus.bubble_ex    = w_bubble_ex;
    assign bus.flush_id     = w_flush_id;
    assign bus.mem_err      = (r_state == S_ERR);
    assign bus.state        = r_state;
    assign bus.stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed and random stimulus against a cycle-level behavioural
//          model of the hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [2:0] LD  = 3'b001;
    localparam logic [2:0] ST  = 3'b010;
    localparam int         TMO = 15;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(
        .LD_FLAG     (LD),
        .ST_FLAG     (ST),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: error flag, run length of unacknowledged access cycles,
    // "load-use stall just taken" flag, total stalled cycles
    bit m_err;
    bit m_ld;
    int m_wait;
    int m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rd_addr = 5'd0; bus.ex_rd_we = 1'b0;
        bus.ex_mem_flag = 3'd0; bus.ex_branch_taken = 1'b0;
        bus.mem_mem_flag = 3'd0; bus.mem_ack = 1'b0;
    endtask

    function automatic logic [6:0] ctl_vec();
        return {bus.mem_req, bus.stall_if, bus.stall_id, bus.stall_ex,
                bus.hold_ex_mem, bus.bubble_ex, bus.flush_id};
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit acc, req, frz, raw, haz;
        bit sif, sex, bub, fl;
        logic [1:0] e_st;
        #1;
        acc = (bus.mem_mem_flag == LD) || (bus.mem_mem_flag == ST);
        req = acc && !m_err;
        frz = req && !bus.mem_ack;
        raw = (bus.ex_mem_flag == LD) && bus.ex_rd_we && (bus.ex_rd_addr != 0) &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd_addr) ||
               (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd_addr));
        haz = raw && !m_err && (m_wait == 0) && !m_ld;
        sif = 0; sex = 0; bub = 0; fl = 0;
        if (m_err || frz) begin
            sif = 1; sex = 1;
        end else if (bus.ex_branch_taken) begin
            fl = 1; bub = 1;
        end else if (haz) begin
            sif = 1; bub = 1;
        end
        e_st = m_err ? 2'd3 : (m_wait > 0) ? 2'd2 : m_ld ? 2'd1 : 2'd0;
        check("ctl", {25'd0, ctl_vec()}, {25'd0, req, sif, sif, sex, sex, bub, fl});
        check("state", {30'd0, bus.state}, {30'd0, e_st});
        check("mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
        check("stall_cycles", {16'd0, bus.stall_cycles}, m_stall);
        @(posedge clk);
        if (sif && m_stall < 65535) m_stall++;
        if (m_err) begin
        end else if (m_wait > 0) begin
            if (acc && bus.mem_ack) m_wait = 0;
            else if (m_wait == TMO) m_err = 1;
            else m_wait++;
        end else begin
            m_ld = 0;
            if (frz) m_wait = 1;
            else if (haz && !bus.ex_branch_taken) m_ld = 1;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting at a falling edge; inputs left as-is
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_ctl", {25'd0, ctl_vec()}, 32'd0);
        check("rst_state", {30'd0, bus.state}, 32'd0);
        check("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
        check("rst_stall_cycles", {16'd0, bus.stall_cycles}, 32'd0);
        m_err = 0; m_ld = 0; m_wait = 0; m_stall = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ack_pct;
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Load-use on rs2: one stall cycle, RUN -> LDUSE -> RUN
        bus.ex_mem_flag = LD; bus.ex_rd_we = 1'b1; bus.ex_rd_addr = 5'd5;
        bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
        step();
        check("ldu_state", {30'd0, bus.state}, 32'd1);
        check("ldu_stall_cnt", {16'd0, bus.stall_cycles}, 32'd1);
        step();
        check("ldu_back", {30'd0, bus.state}, 32'd0);
        bus.ex_rd_addr = 5'd0; bus.id_rs2 = 5'd0;
        step();
        bus.ex_rd_addr = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b0;
        step();
        check("nohaz_stall_cnt", {16'd0, bus.stall_cycles}, 32'd1);
        // Branch beats a concurrent load-use hazard
        bus.id_use_rs2 = 1'b1; bus.ex_branch_taken = 1'b1;
        step();
        idle_inputs();
        step();

        // Store acked on its fourth cycle: three frozen cycles
        do_reset();
        bus.mem_mem_flag = ST;
        repeat (3) step();
        bus.mem_ack = 1'b1;
        step();
        check("sw_state", {30'd0, bus.state}, 32'd0);
        check("sw_stall_cnt", {16'd0, bus.stall_cycles}, 32'd3);
        idle_inputs();
        step();

        // Load never acked: ERR after the waiting cycles run out
        do_reset();
        bus.mem_mem_flag = LD;
        repeat (TMO) step();
        check("tmo_wait", {30'd0, bus.state}, 32'd2);
        step();
        check("tmo_err_state", {30'd0, bus.state}, 32'd3);
        check("tmo_err_flag", {31'd0, bus.mem_err}, 32'd1);
        repeat (3) step();
        do_reset();
        repeat (5) step();
        do_reset();
        idle_inputs();

        // Random traffic
        ack_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) ack_pct = (i % 600 == 0) ? 10 : (i % 400 == 0) ? 90 : 50;
            bus.id_rs1          = 5'($urandom_range(0, 3));
            bus.id_rs2          = 5'($urandom_range(0, 3));
            bus.id_use_rs1      = 1'($urandom_range(0, 1));
            bus.id_use_rs2      = 1'($urandom_range(0, 1));
            bus.ex_rd_addr      = 5'($urandom_range(0, 3));
            bus.ex_rd_we        = 1'($urandom_range(0, 3) != 0);
            bus.ex_mem_flag     = 3'($urandom_range(0, 3));
            bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) bus.mem_mem_flag = 3'($urandom_range(0, 4));
            bus.mem_ack         = ($urandom_range(0, 99) < ack_pct);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        // Saturation of the stall counter while parked in ERR
        idle_inputs();
        do_reset();
        bus.mem_mem_flag = LD;
        for (int i = 0; i < 70000 && m_stall < 65535; i++) step();
        repeat (4) step();
        check("stall_saturate", {16'd0, bus.stall_cycles}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
